// File: rtl/tx_link_scheduler.sv
// tx_link_scheduler: brings up the PHY TX link with a fixed run of training
// words, then arbitrates two 32-bit requesters onto one registered TX word.
// The requester that currently owns the link keeps it for up to BURST_LEN
// words while the other one waits. A lone requester is never throttled.
module tx_link_scheduler #(
   parameter int unsigned TRAIN_WORDS = 4,
   parameter int unsigned BURST_LEN   = 4
) (
   input  logic        clk_f,
   input  logic        reset,
   input  logic        link_en,
   input  logic [31:0] req0_data,
   input  logic [31:0] req1_data,
   input  logic        req0_valid,
   input  logic        req1_valid,
   output logic        req0_ready,
   output logic        req1_ready,
   output logic [31:0] data_input,
   output logic        valid,
   output logic        active
);

   localparam logic [31:0] TRAIN_SYM  = 32'hBCBCBCBC;
   localparam logic [31:0] IDLE_SYM   = 32'h7C7C7C7C;
   localparam logic [7:0]  TRAIN_LAST = 8'(TRAIN_WORDS);
   localparam logic [7:0]  BURST_MAX  = 8'(BURST_LEN);

   typedef enum logic [1:0] {
      IDLE,
      TRAIN,
      ACTIVE
   } state_t;

   state_t      state;
   logic        owner;
   logic [7:0]  burst_cnt;
   logic [7:0]  train_cnt;

   logic        valid_o;
   logic        valid_x;
   logic        sel_any;
   logic        sel;
   logic        go;
   logic [31:0] sel_data;

   // Arbitration: owner keeps the link until its burst is used up, unless the
   // other requester is silent; otherwise the other requester takes over.
   always_comb begin
      valid_o = owner ? req1_valid : req0_valid;
      valid_x = owner ? req0_valid : req1_valid;
      sel_any = 1'b0;
      sel     = owner;
      if (valid_o && ((burst_cnt < BURST_MAX) || !valid_x)) begin
         sel_any = 1'b1;
         sel     = owner;
      end else if (valid_x) begin
         sel_any = 1'b1;
         sel     = ~owner;
      end
      go         = (state == ACTIVE) && link_en && !reset && sel_any;
      req0_ready = go && !sel && req0_valid;
      req1_ready = go &&  sel && req1_valid;
      sel_data   = sel ? req1_data : req0_data;
   end

   // Link state machine with registered TX word, valid and active outputs.
   always_ff @(posedge clk_f) begin
      if (reset) begin
         state      <= IDLE;
         owner      <= 1'b0;
         burst_cnt  <= '0;
         train_cnt  <= '0;
         data_input <= '0;
         valid      <= 1'b0;
         active     <= 1'b0;
      end else if (!link_en) begin
         state      <= IDLE;
         train_cnt  <= '0;
         data_input <= '0;
         valid      <= 1'b0;
         active     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state      <= TRAIN;
               train_cnt  <= '0;
               data_input <= '0;
               valid      <= 1'b0;
               active     <= 1'b0;
            end
            TRAIN: begin
               data_input <= TRAIN_SYM;
               valid      <= 1'b1;
               active     <= 1'b0;
               train_cnt  <= train_cnt + 8'd1;
               if (train_cnt + 8'd1 == TRAIN_LAST) begin
                  state     <= ACTIVE;
                  burst_cnt <= '0;
               end
            end
            ACTIVE: begin
               active <= 1'b1;
               if (go) begin
                  data_input <= sel_data;
                  valid      <= 1'b1;
                  if (sel == owner) begin
                     if (burst_cnt < BURST_MAX)
                        burst_cnt <= burst_cnt + 8'd1;
                  end else begin
                     owner     <= sel;
                     burst_cnt <= 8'd1;
                  end
               end else begin
                  data_input <= IDLE_SYM;
                  valid      <= 1'b0;
                  burst_cnt  <= '0;
               end
            end
            default: begin
               state      <= IDLE;
               data_input <= '0;
               valid      <= 1'b0;
               active     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tx_link_scheduler.sv
// Directed bench for tx_link_scheduler: a table of per-cycle vectors covering
// startup, single requester, gap, disable and reset-in-training, followed by
// hand-written contention and lone-requester sequences.
module tb_tx_link_scheduler;

   logic        clk_f = 1'b0;
   logic        reset;
   logic        link_en;
   logic [31:0] req0_data;
   logic [31:0] req1_data;
   logic        req0_valid;
   logic        req1_valid;
   logic        req0_ready;
   logic        req1_ready;
   logic [31:0] data_input;
   logic        valid;
   logic        active;

   int checks = 0;
   int passes = 0;

   tx_link_scheduler #(.TRAIN_WORDS(4), .BURST_LEN(4)) dut (
      .clk_f      (clk_f),
      .reset      (reset),
      .link_en    (link_en),
      .req0_data  (req0_data),
      .req1_data  (req1_data),
      .req0_valid (req0_valid),
      .req1_valid (req1_valid),
      .req0_ready (req0_ready),
      .req1_ready (req1_ready),
      .data_input (data_input),
      .valid      (valid),
      .active     (active)
   );

   always #5 clk_f = ~clk_f;

   typedef struct {
      logic        rst;
      logic        en;
      logic        v0;
      logic [31:0] d0;
      logic        v1;
      logic [31:0] d1;
      logic        r0;
      logic        r1;
      logic [31:0] dat;
      logic        val;
      logic        act;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic rst, logic en, logic v0, logic [31:0] d0,
                               logic v1, logic [31:0] d1, logic r0, logic r1,
                               logic [31:0] dat, logic val, logic act);
      vec_t v;
      v.rst = rst; v.en = en; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
      v.r0 = r0; v.r1 = r1; v.dat = dat; v.val = val; v.act = act;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act_v,
                      input logic [31:0] exp_v);
      checks++;
      if (act_v === exp_v) passes++;
      else $display("FAIL %s step %0d: got %h expected %h", name, idx, act_v, exp_v);
   endtask

   // Drive one cycle of inputs, check readies mid-cycle, then check the
   // registered outputs just after the edge.
   task automatic step(input vec_t v, input int idx);
      reset      = v.rst;
      link_en    = v.en;
      req0_valid = v.v0;
      req0_data  = v.d0;
      req1_valid = v.v1;
      req1_data  = v.d1;
      @(negedge clk_f);
      chk("req0_ready", idx, {31'd0, req0_ready}, {31'd0, v.r0});
      chk("req1_ready", idx, {31'd0, req1_ready}, {31'd0, v.r1});
      @(posedge clk_f);
      #1;
      chk("data_input", idx, data_input, v.dat);
      chk("valid", idx, {31'd0, valid}, {31'd0, v.val});
      chk("active", idx, {31'd0, active}, {31'd0, v.act});
   endtask

   localparam logic [31:0] BC = 32'hBCBCBCBC;
   localparam logic [31:0] IS = 32'h7C7C7C7C;

   initial begin
      reset = 1'b1; link_en = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_data = '0; req1_data = '0;

      // startup: reset, 4 training words, then idle symbols
      tbl.push_back(mk(1,0,0,0,0,0, 0,0, 32'h0,0,0));
      tbl.push_back(mk(1,0,0,0,0,0, 0,0, 32'h0,0,0));
      tbl.push_back(mk(0,1,0,0,0,0, 0,0, 32'h0,0,0));
      tbl.push_back(mk(0,1,0,0,0,0, 0,0, BC,1,0));
      tbl.push_back(mk(0,1,0,0,0,0, 0,0, BC,1,0));
      tbl.push_back(mk(0,1,0,0,0,0, 0,0, BC,1,0));
      tbl.push_back(mk(0,1,0,0,0,0, 0,0, BC,1,0));
      tbl.push_back(mk(0,1,0,0,0,0, 0,0, IS,0,1));
      // single requester stream
      tbl.push_back(mk(0,1,1,32'hFFFFEEEE,0,0, 1,0, 32'hFFFFEEEE,1,1));
      tbl.push_back(mk(0,1,1,32'hFFEEEEEE,0,0, 1,0, 32'hFFEEEEEE,1,1));
      tbl.push_back(mk(0,1,1,32'hCCEEEEEE,0,0, 1,0, 32'hCCEEEEEE,1,1));
      tbl.push_back(mk(0,1,1,32'hAAAA1234,0,0, 1,0, 32'hAAAA1234,1,1));
      tbl.push_back(mk(0,1,1,32'h12345678,0,0, 1,0, 32'h12345678,1,1));
      tbl.push_back(mk(0,1,1,32'hBBBBAAAA,0,0, 1,0, 32'hBBBBAAAA,1,1));
      // gap: 2 words, idle, then contention gives req0 a fresh burst of 4
      tbl.push_back(mk(0,1,0,0,0,0, 0,0, IS,0,1));
      tbl.push_back(mk(0,1,1,32'h11110001,0,0, 1,0, 32'h11110001,1,1));
      tbl.push_back(mk(0,1,1,32'h11110002,0,0, 1,0, 32'h11110002,1,1));
      tbl.push_back(mk(0,1,0,0,0,0, 0,0, IS,0,1));
      tbl.push_back(mk(0,1,1,32'hA0000001,1,32'hB0000001, 1,0, 32'hA0000001,1,1));
      tbl.push_back(mk(0,1,1,32'hA0000002,1,32'hB0000002, 1,0, 32'hA0000002,1,1));
      tbl.push_back(mk(0,1,1,32'hA0000003,1,32'hB0000003, 1,0, 32'hA0000003,1,1));
      tbl.push_back(mk(0,1,1,32'hA0000004,1,32'hB0000004, 1,0, 32'hA0000004,1,1));
      tbl.push_back(mk(0,1,1,32'hA0000005,1,32'hB0000005, 0,1, 32'hB0000005,1,1));
      tbl.push_back(mk(0,1,1,32'hA0000006,1,32'hB0000006, 0,1, 32'hB0000006,1,1));
      // disable mid-burst, then re-enable and retrain (requests ignored in TRAIN)
      tbl.push_back(mk(0,0,1,32'hA0000007,1,32'hB0000007, 0,0, 32'h0,0,0));
      tbl.push_back(mk(0,0,0,0,0,0, 0,0, 32'h0,0,0));
      tbl.push_back(mk(0,1,0,0,0,0, 0,0, 32'h0,0,0));
      tbl.push_back(mk(0,1,0,0,0,0, 0,0, BC,1,0));
      tbl.push_back(mk(0,1,1,32'h55555555,0,0, 0,0, BC,1,0));
      tbl.push_back(mk(0,1,0,0,0,0, 0,0, BC,1,0));
      tbl.push_back(mk(0,1,0,0,0,0, 0,0, BC,1,0));
      tbl.push_back(mk(0,1,0,0,0,0, 0,0, IS,0,1));
      // reset overrides link_en and blocks acceptance
      tbl.push_back(mk(1,1,1,32'h66666666,0,0, 0,0, 32'h0,0,0));
      tbl.push_back(mk(0,1,0,0,0,0, 0,0, 32'h0,0,0));
      tbl.push_back(mk(0,1,0,0,0,0, 0,0, BC,1,0));
      tbl.push_back(mk(0,1,0,0,0,0, 0,0, BC,1,0));
      // reset in TRAIN after 2 words, full retrain with link_en held
      tbl.push_back(mk(1,1,0,0,0,0, 0,0, 32'h0,0,0));
      tbl.push_back(mk(0,1,0,0,0,0, 0,0, 32'h0,0,0));
      tbl.push_back(mk(0,1,0,0,0,0, 0,0, BC,1,0));
      tbl.push_back(mk(0,1,0,0,0,0, 0,0, BC,1,0));
      tbl.push_back(mk(0,1,0,0,0,0, 0,0, BC,1,0));
      tbl.push_back(mk(0,1,0,0,0,0, 0,0, BC,1,0));
      tbl.push_back(mk(0,1,0,0,0,0, 0,0, IS,0,1));

      for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

      // contention after reset: owner 0 wins first, then 4/4 alternation
      for (int j = 0; j < 16; j++) begin
         vec_t v;
         logic who;
         who = ((j / 4) % 2) == 1;
         v = mk(0, 1, 1, 32'hD0000000 + 32'(j), 1, 32'hE0000000 + 32'(j),
                !who, who, who ? 32'hE0000000 + 32'(j) : 32'hD0000000 + 32'(j), 1, 1);
         step(v, 100 + j);
      end

      // req1 now owns with a spent burst; alone it is served every cycle
      for (int j = 0; j < 6; j++) begin
         vec_t v;
         v = mk(0, 1, 0, 0, 1, 32'hF0000000 + 32'(j), 0, 1, 32'hF0000000 + 32'(j), 1, 1);
         step(v, 200 + j);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
